// File: rtl/uart_tx_frame_if.sv
// Input-side word handshake for uart_tx_frame: producer drives data_in/data_in_valid,
// the transmitter answers with data_in_ready.
interface uart_tx_frame_if #(
   parameter int unsigned DATA_BITS = 8
) ();
   logic [DATA_BITS-1:0] data_in;
   logic                 data_in_valid;
   logic                 data_in_ready;

   modport master (output data_in, output data_in_valid, input data_in_ready);
   modport slave  (input data_in, input data_in_valid, output data_in_ready);
endinterface

// File: rtl/uart_tx_frame.sv
// Parametrised UART transmitter: start, DATA_BITS payload LSB first, optional parity, 1-2 stop bits.
// Define UART_TX_FIFO_EN to put a FIFO_DEPTH-entry FIFO in front of the framer (zero-gap frames).
module uart_tx_frame #(
   parameter int unsigned CLOCK_FREQ  = 50_000_000,
   parameter int unsigned BAUD_RATE   = 115_200,
   parameter int unsigned DATA_BITS   = 8,
   parameter int unsigned PARITY_MODE = 0,
   parameter int unsigned STOP_BITS   = 1,
   parameter int unsigned FIFO_DEPTH  = 4
) (
   input  logic           clk,
   input  logic           rst_n,
   uart_tx_frame_if.slave in_if,
   output logic           serial_out,
   output logic           tx_busy
);
   localparam int unsigned SET = CLOCK_FREQ / BAUD_RATE;
   localparam int unsigned SW  = (SET >= 2) ? $clog2(SET) : 1;
   localparam logic [SW-1:0] SYM_LAST  = SW'(SET - 1);
   localparam logic [3:0]    DATA_LAST = 4'(DATA_BITS - 1);
   localparam logic [3:0]    STOP_LAST = 4'(STOP_BITS - 1);
   localparam bit HAS_PAR = (PARITY_MODE != 0);
   localparam bit ODD_PAR = (PARITY_MODE == 2);

   localparam logic [2:0] IDLE   = 3'd0;
   localparam logic [2:0] START  = 3'd1;
   localparam logic [2:0] DATA   = 3'd2;
   localparam logic [2:0] PARITY = 3'd3;
   localparam logic [2:0] STOP   = 3'd4;

   if (SET < 2) begin : g_bad_set
      $error("uart_tx_frame: CLOCK_FREQ/BAUD_RATE must be at least 2");
   end
   if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data
      $error("uart_tx_frame: DATA_BITS must be 5..9");
   end
   if (PARITY_MODE > 2) begin : g_bad_par
      $error("uart_tx_frame: PARITY_MODE must be 0, 1 or 2");
   end
   if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop
      $error("uart_tx_frame: STOP_BITS must be 1 or 2");
   end
   if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
      $error("uart_tx_frame: FIFO_DEPTH must be a power of two >= 2");
   end

   logic [2:0]           state;
   logic [SW-1:0]        sym_cnt;
   logic [3:0]           bit_cnt;
   logic [DATA_BITS-1:0] shreg;
   logic                 par_bit;
   logic                 line_bit;
   logic                 sym_last;
   logic                 frame_done;
   logic                 load;
   logic [DATA_BITS-1:0] load_word;

   assign sym_last   = (sym_cnt == SYM_LAST);
   assign frame_done = (state == STOP) && sym_last && (bit_cnt == STOP_LAST);

`ifdef UART_TX_FIFO_EN
   localparam int unsigned AW = $clog2(FIFO_DEPTH);

   logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
   logic [AW-1:0]        wr_ptr;
   logic [AW-1:0]        rd_ptr;
   logic [AW:0]          count;
   logic                 fifo_empty;
   logic                 push;
   logic                 pop;

   assign fifo_empty          = (count == '0);
   assign in_if.data_in_ready = (count != (AW+1)'(FIFO_DEPTH));
   assign push                = in_if.data_in_valid && in_if.data_in_ready;
   // Popping on the final stop cycle lets the next start bit follow with no idle gap.
   assign pop                 = !fifo_empty && ((state == IDLE) || frame_done);
   assign load                = pop;
   assign load_word           = mem[rd_ptr];
   assign tx_busy             = (state != IDLE) || !fifo_empty;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= in_if.data_in;
   end
`else
   assign in_if.data_in_ready = (state == IDLE);
   assign load                = in_if.data_in_valid && (state == IDLE);
   assign load_word           = in_if.data_in;
   assign tx_busy             = (state != IDLE);
`endif

   always_comb begin
      line_bit = 1'b1;
      case (state)
         START:   line_bit = 1'b0;
         DATA:    line_bit = shreg[0];
         PARITY:  line_bit = par_bit;
         default: line_bit = 1'b1;
      endcase
   end

   // serial_out follows the state's line level one cycle later, so it is a clean register output.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         sym_cnt    <= '0;
         bit_cnt    <= '0;
         shreg      <= '0;
         par_bit    <= 1'b0;
         serial_out <= 1'b1;
      end else begin
         serial_out <= line_bit;
         if (load) begin
            state   <= START;
            sym_cnt <= '0;
            bit_cnt <= '0;
            shreg   <= load_word;
            par_bit <= (^load_word) ^ ODD_PAR;
         end else if (state != IDLE) begin
            sym_cnt <= sym_last ? '0 : sym_cnt + 1'b1;
            if (sym_last) begin
               case (state)
                  START: begin
                     state   <= DATA;
                     bit_cnt <= '0;
                  end
                  DATA: begin
                     shreg <= shreg >> 1;
                     if (bit_cnt == DATA_LAST) begin
                        bit_cnt <= '0;
                        state   <= HAS_PAR ? PARITY : STOP;
                     end else begin
                        bit_cnt <= bit_cnt + 1'b1;
                     end
                  end
                  PARITY: begin
                     state   <= STOP;
                     bit_cnt <= '0;
                  end
                  STOP: begin
                     if (frame_done) state <= IDLE;
                     else            bit_cnt <= bit_cnt + 1'b1;
                  end
                  default: state <= IDLE;
               endcase
            end
         end
      end
   end
endmodule

// File: tb/tb_uart_tx_frame.sv
// Scoreboard bench for uart_tx_frame: three configurations (8N1, 8O1, 5E2) at 10 clocks per symbol,
// random traffic, held-valid back-to-back traffic and a mid-frame asynchronous reset.
module tb_uart_tx_frame;
   localparam int unsigned SET   = 10;
   localparam int unsigned DEPTH = 4;
`ifdef UART_TX_FIFO_EN
   localparam int unsigned LAT = 2;
`else
   localparam int unsigned LAT = 1;
`endif

   typedef struct {
      int unsigned data;
      int unsigned s;
   } exp_t;

   logic       clk   = 1'b0;
   logic       rst_n = 1'b0;
   logic       vld [3];
   logic [8:0] din [3];
   logic [2:0] rdy_v, so_v, busy_v;
   logic       so0, so1, so2, bz0, bz1, bz2;
   bit         abort = 1'b0;

   int unsigned cyc    = 0;
   int unsigned checks = 0;
   int unsigned errs   = 0;

   exp_t        q0[$], q1[$], q2[$];
   int unsigned n_acc [3];
   int unsigned s_hist [3][8];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   uart_tx_frame_if #(.DATA_BITS(8)) if0 ();
   uart_tx_frame_if #(.DATA_BITS(8)) if1 ();
   uart_tx_frame_if #(.DATA_BITS(5)) if2 ();

   assign if0.data_in = din[0][7:0];
   assign if1.data_in = din[1][7:0];
   assign if2.data_in = din[2][4:0];
   assign if0.data_in_valid = vld[0];
   assign if1.data_in_valid = vld[1];
   assign if2.data_in_valid = vld[2];
   assign rdy_v  = {if2.data_in_ready, if1.data_in_ready, if0.data_in_ready};
   assign so_v   = {so2, so1, so0};
   assign busy_v = {bz2, bz1, bz0};

   uart_tx_frame #(.CLOCK_FREQ(100), .BAUD_RATE(10), .DATA_BITS(8), .PARITY_MODE(0),
                   .STOP_BITS(1), .FIFO_DEPTH(DEPTH)) dut0 (
      .clk(clk), .rst_n(rst_n), .in_if(if0), .serial_out(so0), .tx_busy(bz0));
   uart_tx_frame #(.CLOCK_FREQ(100), .BAUD_RATE(10), .DATA_BITS(8), .PARITY_MODE(2),
                   .STOP_BITS(1), .FIFO_DEPTH(DEPTH)) dut1 (
      .clk(clk), .rst_n(rst_n), .in_if(if1), .serial_out(so1), .tx_busy(bz1));
   uart_tx_frame #(.CLOCK_FREQ(100), .BAUD_RATE(10), .DATA_BITS(5), .PARITY_MODE(1),
                   .STOP_BITS(2), .FIFO_DEPTH(DEPTH)) dut2 (
      .clk(clk), .rst_n(rst_n), .in_if(if2), .serial_out(so2), .tx_busy(bz2));

   function automatic int unsigned cfg_db(input int unsigned k);
      return (k == 2) ? 5 : 8;
   endfunction
   function automatic int unsigned cfg_pm(input int unsigned k);
      return (k == 1) ? 2 : (k == 2) ? 1 : 0;
   endfunction
   function automatic int unsigned cfg_sb(input int unsigned k);
      return (k == 2) ? 2 : 1;
   endfunction
   function automatic int unsigned nsym(input int unsigned k);
      return 1 + cfg_db(k) + ((cfg_pm(k) != 0) ? 1 : 0) + cfg_sb(k);
   endfunction

   function automatic void push_exp(input int unsigned k, input exp_t e);
      case (k)
         0:       q0.push_back(e);
         1:       q1.push_back(e);
         default: q2.push_back(e);
      endcase
   endfunction
   function automatic exp_t pop_exp(input int unsigned k);
      case (k)
         0:       return q0.pop_front();
         1:       return q1.pop_front();
         default: return q2.pop_front();
      endcase
   endfunction
   function automatic int unsigned q_size(input int unsigned k);
      case (k)
         0:       return q0.size();
         1:       return q1.size();
         default: return q2.size();
      endcase
   endfunction
   function automatic void clear_model();
      q0.delete();
      q1.delete();
      q2.delete();
      for (int unsigned k = 0; k < 3; k++) n_acc[k] = 0;
   endfunction

   // Expected level of symbol j of a frame carrying word d.
   function automatic int unsigned sym_bit(input int unsigned k, input int unsigned d, input int unsigned j);
      int unsigned ones;
      if (j == 0) return 0;
      if (j <= cfg_db(k)) return (d >> (j - 1)) & 1;
      if (cfg_pm(k) != 0 && j == cfg_db(k) + 1) begin
         ones = $countones(d);
         return (cfg_pm(k) == 1) ? (ones % 2) : (1 - ones % 2);
      end
      return 1;
   endfunction

   // Busy during the cycle ending at edge t: last frame's line ends at edge s+L, busy drops one edge earlier.
   function automatic bit exp_busy(input int unsigned k, input int unsigned t);
      int unsigned last;
      if (n_acc[k] == 0) return 1'b0;
      last = s_hist[k][(n_acc[k] - 1) % 8];
      return (t + 1 <= last + nsym(k) * SET);
   endfunction

   function automatic bit exp_ready(input int unsigned k, input int unsigned t);
`ifdef UART_TX_FIFO_EN
      int unsigned cnt = 0;
      for (int unsigned i = 0; i < n_acc[k] && i < 8; i++)
         if (s_hist[k][(n_acc[k] - 1 - i) % 8] > t) cnt++;
      return cnt < DEPTH;
`else
      return !exp_busy(k, t);
`endif
   endfunction

   function automatic void record_accept(input int unsigned k, input int unsigned t, input int unsigned d);
      exp_t        e;
      int unsigned s = t + LAT;
      int unsigned last;
      if (n_acc[k] != 0) begin
         last = s_hist[k][(n_acc[k] - 1) % 8] + nsym(k) * SET;
         if (last > s) s = last;
      end
      s_hist[k][n_acc[k] % 8] = s;
      n_acc[k]++;
      e.data = d;
      e.s    = s;
      push_exp(k, e);
   endfunction

   task automatic chk(input string name, input int unsigned k, input int unsigned act, input int unsigned exp);
      checks++;
      if (act != exp) begin
         errs++;
         $display("FAIL %s dut%0d cycle %0d: got %0d expected %0d", name, k, cyc, act, exp);
      end
   endtask

   // Called just after a negedge: checks handshake outputs for the coming edge, then drives it.
   task automatic drive_cycle(input int unsigned k, input bit v, input int unsigned d);
      int unsigned t  = cyc + 1;
      int unsigned dm = d & ((1 << cfg_db(k)) - 1);
      bit          er = exp_ready(k, t);
      chk("tx_busy", k, busy_v[k], exp_busy(k, t));
      chk("data_in_ready", k, rdy_v[k], er);
      vld[k] = v;
      din[k] = 9'(dm);
      if (v && er) record_accept(k, t, dm);
      @(negedge clk);
   endtask

   task automatic stim(input int unsigned k, input int unsigned nrand, input int unsigned nheld);
      for (int unsigned i = 0; i < nrand; i++) drive_cycle(k, ($urandom_range(0, 5) == 0), $urandom);
      for (int unsigned i = 0; i < nheld; i++) drive_cycle(k, 1'b1, $urandom);
      drive_cycle(k, 1'b0, 0);
   endtask

   task automatic monitor(input int unsigned k);
      exp_t        e;
      int unsigned b;
      int unsigned act;
      bit          bad;
      forever begin
         @(negedge clk);
         if (!abort && so_v[k] == 1'b0) begin
            chk("frame_expected", k, (q_size(k) != 0) ? 1 : 0, 1);
            if (q_size(k) == 0) begin
               repeat (nsym(k) * SET) @(negedge clk);
            end else begin
               e = pop_exp(k);
               chk("frame_start_cycle", k, cyc, e.s);
               for (int unsigned j = 0; j < nsym(k) && !abort; j++) begin
                  b   = sym_bit(k, e.data, j);
                  bad = 1'b0;
                  act = b;
                  for (int unsigned c = 0; c < SET; c++) begin
                     if (j != 0 || c != 0) @(negedge clk);
                     if (abort) break;
                     if (!bad && so_v[k] != b[0]) begin
                        bad = 1'b1;
                        act = so_v[k];
                     end
                  end
                  if (!abort) chk($sformatf("symbol%0d", j), k, act, b);
               end
            end
         end
      end
   endtask

   function automatic bit quiet();
      for (int unsigned k = 0; k < 3; k++)
         if (q_size(k) != 0 || exp_busy(k, cyc + 1) || busy_v[k] != 1'b0) return 1'b0;
      return 1'b1;
   endfunction

   task automatic drain();
      int unsigned n = 0;
      while (n < 3000 && !quiet()) begin
         @(negedge clk);
         n++;
      end
      chk("drain_idle", 0, quiet(), 1);
      repeat (3) @(negedge clk);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got no finish expected finish before time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      for (int unsigned k = 0; k < 3; k++) begin
         vld[k]   = 1'b0;
         din[k]   = '0;
         n_acc[k] = 0;
      end
      fork
         monitor(0);
         monitor(1);
         monitor(2);
      join_none

      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      for (int unsigned k = 0; k < 3; k++) begin
         chk("reset_serial_out", k, so_v[k], 1);
         chk("reset_ready", k, rdy_v[k], 1);
         chk("reset_busy", k, busy_v[k], 0);
      end
      rst_n = 1'b1;
      @(negedge clk);

      fork
         stim(0, 1500, 5 * (nsym(0) * SET + 2));
         stim(1, 1500, 5 * (nsym(1) * SET + 2));
         stim(2, 1500, 5 * (nsym(2) * SET + 2));
      join
      drain();

      // Abort every DUT in the middle of data bit 2 (frame cycle 35), which is forced to 0.
      fork
         drive_cycle(0, 1'b1, $urandom & ~32'h4);
         drive_cycle(1, 1'b1, $urandom & ~32'h4);
         drive_cycle(2, 1'b1, $urandom & ~32'h4);
      join
      for (int unsigned i = 0; i < 35; i++) begin
         fork
            drive_cycle(0, 1'b0, 0);
            drive_cycle(1, 1'b0, 0);
            drive_cycle(2, 1'b0, 0);
         join
      end
      #2;
      abort = 1'b1;
      rst_n = 1'b0;
      #1;
      for (int unsigned k = 0; k < 3; k++) begin
         chk("abort_serial_out", k, so_v[k], 1);
         chk("abort_ready", k, rdy_v[k], 1);
         chk("abort_busy", k, busy_v[k], 0);
      end
      clear_model();
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      abort = 1'b0;

      fork
         stim(0, 200, 2 * (nsym(0) * SET + 2));
         stim(1, 200, 2 * (nsym(1) * SET + 2));
         stim(2, 200, 2 * (nsym(2) * SET + 2));
      join
      drain();

      $display("CHECKS %0d ERRORS %0d", checks, errs);
      $finish;
   end
endmodule

// File: doc/uart_tx_frame.md
# uart_tx_frame

Parametrised UART transmitter for the IO-circuits layer. It serialises words of configurable width with optional parity and one or two stop bits. Handshake on the input side is valid/ready. An optional input FIFO allows back-to-back frames with no idle gap. It replaces the fixed 8N1 transmitter wherever the CPU memory-mapped UART needs a different frame format.

## Interface
- `CLOCK_FREQ`, 50_000_000: clock frequency in Hz.
- `BAUD_RATE`, 115_200: line rate in bit/s.
- `DATA_BITS`, 8: payload width; legal range 5..9.
- `PARITY_MODE`, 0: 0 = none, 1 = even, 2 = odd.
- `STOP_BITS`, 1: stop-bit count; legal values 1 or 2.
- `FIFO_DEPTH`, 4: FIFO entries; power of two, at least 2. Used only with `UART_TX_FIFO_EN`.

Ports:
- `clk`, input, 1: the single clock.
- `rst_n`, input, 1: asynchronous, active-low reset.
- `data_in`, input, DATA_BITS: word to transmit.
- `data_in_valid`, input, 1: producer has a word.
- `data_in_ready`, output, 1: block accepts a word this cycle.
- `serial_out`, output, 1: TX line, idle high.
- `tx_busy`, output, 1: high while a frame is in flight or the FIFO is non-empty.

## Operation
- `SYMBOL_EDGE_TIME` = CLOCK_FREQ / BAUD_RATE, using integer division. It must be at least 2; elaboration fails otherwise. Illegal `DATA_BITS`, `PARITY_MODE` or `STOP_BITS` values also fail elaboration.
- Frame order:
  - start bit (0);
  - DATA_BITS payload bits, LSB first;
  - parity bit, only if PARITY_MODE != 0;
  - STOP_BITS stop bits (1).
- Parity bit:
  - even mode sends XOR-reduce of the latched word;
  - odd mode sends its inverse.
- A transfer happens on a rising edge where `data_in_valid && data_in_ready`. The word is latched on that edge. `data_in` may change afterwards.
- FSM states: IDLE, START, DATA, PARITY, STOP.
- Transitions:
  - IDLE→START on an accept (no FIFO) or when the FIFO is non-empty;
  - START→DATA after one symbol;
  - DATA→PARITY, or DATA→STOP when there is no parity, after the DATA_BITS-th symbol;
  - PARITY→STOP after one symbol;
  - STOP→IDLE after STOP_BITS symbols. With the FIFO, STOP goes directly to START instead when the FIFO is non-empty.
- Two counters:
  - a symbol counter of $clog2(SYMBOL_EDGE_TIME) bits, which wraps at SYMBOL_EDGE_TIME-1 and restarts at 0 on entering START;
  - a 4-bit bit counter within DATA/STOP.
- `serial_out` is registered. In IDLE it is 1.
- Reset values:
  - `serial_out` = 1, `data_in_ready` = 1, `tx_busy` = 0;
  - FSM in IDLE, both counters 0, FIFO empty.
- Reset mid-frame aborts the frame immediately and asynchronously: the line returns high and the FIFO contents are discarded.

## Timing
- Latency: for a word accepted on edge N with the FSM in IDLE, `serial_out` falls on edge N+1.
- Every symbol, including each stop bit, is held for exactly SYMBOL_EDGE_TIME cycles.
- Frame length is (1 + DATA_BITS + P + STOP_BITS) × SYMBOL_EDGE_TIME cycles, where P = 1 with parity and 0 without.
- Without the FIFO:
  - `data_in_ready` is 1 only in IDLE;
  - after the last stop symbol the FSM spends at least one IDLE cycle (line high), so consecutive frames are separated by at least 1 extra cycle.
- `tx_busy` rises on the accept edge and falls on the edge that enters IDLE with no pending word.
- `data_in_valid` while not ready is ignored. There is no overflow or loss.

## Configuration
- `UART_TX_FIFO_EN` defined:
  - a FIFO_DEPTH-entry FIFO sits in front of the FSM, and `data_in_ready` = !full;
  - a pop happens on the last cycle of the final stop symbol (or in IDLE), so consecutive frames have zero gap;
  - a simultaneous push and pop when full is not accepted, because ready is already low;
  - a simultaneous push and pop when empty passes through with 1-cycle latency;
  - read and write pointers wrap modulo FIFO_DEPTH.
- `UART_TX_FIFO_EN` not defined: a single holding register only; ready and latency behave exactly as in Timing.

## Test plan
Common settings: CLOCK_FREQ=100, BAUD_RATE=10, so SYMBOL_EDGE_TIME=10.
- 8N1, send 0xA5 → the line, sampled at the mid-point of each symbol, reads 0,1,0,1,0,0,1,0,1,1. The frame is 100 cycles. `tx_busy` is high for 100 cycles. `data_in_ready` is low for the whole frame.
- PARITY_MODE=1, send 0xA5 → parity symbol 0. With PARITY_MODE=2, the parity symbol is 1. The frame is 110 cycles.
- DATA_BITS=5, STOP_BITS=2, send 5'h13 → the line reads 0,1,1,0,0,1,1,1. The stop level lasts 20 cycles.
- Assert `rst_n`=0 at cycle 35 of a frame → `serial_out`=1 and `data_in_ready`=1 immediately. After release, the next accepted word produces a clean frame.
- With `UART_TX_FIFO_EN` and FIFO_DEPTH=4, push 5 words with `data_in_valid` held high:
  - `data_in_ready` drops once 4 words are queued, and the 5th is accepted after the first pop;
  - five frames go out back-to-back with no idle cycle between them, 500 cycles total.
- Hold `data_in_valid` high in IDLE with the FIFO disabled → the next frame starts exactly 1 cycle after the previous stop symbol ends.
